// File: rtl/debounce_arbiter.sv
// debounce_arbiter: per-channel sync + tick-based debounce, round-robin arbitration of level-change events.
// Define DBNC_TIMESTAMP_EN to add the evtStamp port carrying the tick count captured at commit.
module debounce_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int PRESCALE     = 1000,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         signalIn,
  output logic [NUM_CH-1:0]         signalOut,
  output logic                      evtValid,
  input  logic                      evtReady,
  output logic [$clog2(NUM_CH)-1:0] evtCh,
  output logic                      evtLevel,
`ifdef DBNC_TIMESTAMP_EN
  output logic [15:0]               evtStamp,
`endif
  output logic                      overflow
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t            r_state, w_state;
  logic [NUM_CH-1:0] r_s1, r_s2, r_pend, r_plvl, w_commit;
  logic [CNT_W-1:0]  r_pre;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CH_W-1:0]   r_last, w_sel, w_idx;
  logic              w_tick, w_load;
  generate
    if ((((PRESCALE - 1) >> CNT_W) != 0) || (((STABLE_TICKS - 1) >> CNT_W) != 0)) begin : g_width_chk
      $error("PRESCALE-1 and STABLE_TICKS-1 must fit in CNT_W bits");
    end
  endgenerate
  assign w_tick   = enable && (r_pre == CNT_W'(PRESCALE - 1));
  assign evtValid = (r_state == OFFER);
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_commit[i] = w_tick && (r_s2[i] != signalOut[i]) && (r_cnt[i] == CNT_W'(STABLE_TICKS - 1));
  end
  // Walk downward so the last hit is the nearest pending channel after lastGrant.
  always_comb begin
    w_sel  = '0;
    w_idx  = '0;
    w_load = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(r_last) + k) % NUM_CH);
      if (r_pend[w_idx]) begin
        w_sel  = w_idx;
        w_load = (r_state == IDLE);
      end
    end
    w_state = (r_state == IDLE) ? (w_load ? OFFER : IDLE) : (evtReady ? IDLE : OFFER);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_pre     <= '0;
      signalOut <= '0;
      r_pend    <= '0;
      r_plvl    <= '0;
      r_last    <= CH_W'(NUM_CH - 1);
      evtCh     <= '0;
      evtLevel  <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1  <= signalIn;
      r_s2  <= r_s1;
      r_pre <= (!enable || w_tick) ? '0 : r_pre + 1'b1;
      if (w_load) begin
        evtCh    <= w_sel;
        evtLevel <= r_plvl[w_sel];
      end
      if (r_state == OFFER && evtReady) r_last <= evtCh;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable || (r_s2[i] == signalOut[i]) || w_commit[i]) r_cnt[i] <= '0;
        else if (w_tick) r_cnt[i] <= r_cnt[i] + 1'b1;
        // A commit racing the load of its own channel re-arms pend without losing anything.
        if (w_commit[i]) begin
          signalOut[i] <= r_s2[i];
          r_pend[i]    <= 1'b1;
          r_plvl[i]    <= r_s2[i];
          if (r_pend[i] && !(w_load && w_sel == CH_W'(i))) overflow <= 1'b1;
        end else if (w_load && w_sel == CH_W'(i)) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end
`ifdef DBNC_TIMESTAMP_EN
  logic [15:0] r_tcnt;
  logic [15:0] r_pstamp [NUM_CH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tcnt   <= '0;
      evtStamp <= '0;
      for (int i = 0; i < NUM_CH; i++) r_pstamp[i] <= '0;
    end else begin
      if (w_tick) r_tcnt <= r_tcnt + 1'b1;
      if (w_load) evtStamp <= r_pstamp[w_sel];
      for (int i = 0; i < NUM_CH; i++)
        if (w_commit[i]) r_pstamp[i] <= r_tcnt;
    end
  end
`endif
endmodule

// File: tb/tb_debounce_arbiter.sv
// tb_debounce_arbiter: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_debounce_arbiter;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int ST = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       evt_ready = 1'b0;
  logic [3:0] signal_in = 4'h0;
  logic [3:0] signal_out;
  logic       evt_valid, evt_level, overflow;
  logic [1:0] evt_ch;
`ifdef DBNC_TIMESTAMP_EN
  logic [15:0] evt_stamp;
`endif
  int total = 0;
  int bad = 0;

  debounce_arbiter #(.NUM_CH(N), .PRESCALE(P), .STABLE_TICKS(ST), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .signalIn(signal_in),
    .signalOut(signal_out),
    .evtValid(evt_valid),
    .evtReady(evt_ready),
    .evtCh(evt_ch),
    .evtLevel(evt_level),
`ifdef DBNC_TIMESTAMP_EN
    .evtStamp(evt_stamp),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] snap();
    return {signal_out, evt_valid, evt_ch, evt_level, overflow};
  endfunction

  task automatic wait_valid(input string name, input int lim);
    for (int k = 0; k < lim && evt_valid !== 1'b1; k++) step(1);
    check(name, evt_valid, 1'b1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    enable = 1'b1;
    signal_in = 4'h0;
    evt_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Behavioural model: input history, ticks counted as cycles-since-enable mod P,
  // a mismatch run length in ticks per channel, one pending slot per channel.
  bit [3:0] m_d1, m_d2, m_out, m_pend, m_plv;
  int       m_phase, m_last;
  int       m_run [N];
  bit       m_valid, m_lvl, m_ovf;
  bit [1:0] m_ch;

  task automatic model_step(input bit rn, input bit en, input bit [3:0] sin, input bit rdy);
    bit [3:0] sync;
    bit [3:0] com;
    bit       tick;
    if (!rn) begin
      m_d1 = 0; m_d2 = 0; m_out = 0; m_pend = 0; m_plv = 0;
      m_phase = 0; m_last = N - 1;
      m_valid = 0; m_lvl = 0; m_ovf = 0; m_ch = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      return;
    end
    sync = m_d2;
    tick = en && (m_phase == P - 1);
    m_d2 = m_d1;
    m_d1 = sin;
    m_phase = en ? (m_phase + 1) % P : 0;
    com = 0;
    for (int i = 0; i < N; i++) begin
      if (!en || sync[i] == m_out[i]) m_run[i] = 0;
      else if (tick) begin
        m_run[i]++;
        if (m_run[i] == ST) begin
          com[i] = 1;
          m_run[i] = 0;
        end
      end
    end
    if (!m_valid) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (m_pend[c]) begin
          m_valid = 1;
          m_ch = 2'(c);
          m_lvl = m_plv[c];
          m_pend[c] = 0;
          break;
        end
      end
    end else if (rdy) begin
      m_valid = 0;
      m_last = int'(m_ch);
    end
    for (int i = 0; i < N; i++) begin
      if (com[i]) begin
        if (m_pend[i]) m_ovf = 1;
        m_pend[i] = 1;
        m_out[i] = ~m_out[i];
        m_plv[i] = m_out[i];
      end
    end
  endtask

  typedef struct {
    bit       rn;
    bit       en;
    bit [3:0] sin;
    int       n;
    bit [3:0] out;
    bit       vld;
    bit [1:0] ch;
    bit       lvl;
    bit       ovf;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int       nchg;
    logic [8:0] s0;
    tbl = '{
      '{0, 1, 4'hF,  2, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF, 11, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF,  1, 4'hF, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF,  1, 4'hF, 1, 2'd0, 1, 0},
      '{1, 1, 4'hF, 10, 4'hF, 1, 2'd0, 1, 0},
      '{0, 1, 4'hF,  1, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'h0, 20, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'h2,  8, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'h0, 20, 4'h0, 0, 2'd0, 0, 0},
      '{1, 0, 4'hF, 30, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF, 11, 4'h0, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF,  1, 4'hF, 0, 2'd0, 0, 0},
      '{1, 1, 4'hF,  1, 4'hF, 1, 2'd0, 1, 0},
      '{0, 1, 4'h0,  2, 4'h0, 0, 2'd0, 0, 0}
    };
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rn;
      enable = tbl[i].en;
      signal_in = tbl[i].sin;
      evt_ready = 1'b0;
      step(tbl[i].n);
      check($sformatf("vec%0d", i), snap(),
            {tbl[i].out, tbl[i].vld, tbl[i].ch, tbl[i].lvl, tbl[i].ovf});
    end

    // Power-up with all inputs high drains four events in channel order.
    rst_n = 1'b0; enable = 1'b1; signal_in = 4'hF; evt_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    wait_valid("t1_wait", 30);
    check("t1_ev0", {evt_ch, evt_level, signal_out}, {2'd0, 1'b1, 4'hF});
    for (int e = 1; e < 4; e++) begin
      step(1);
      check($sformatf("t1_gap%0d", e), evt_valid, 1'b0);
      step(1);
      check($sformatf("t1_ev%0d", e), {evt_valid, evt_ch, evt_level}, {1'b1, 2'(e), 1'b1});
    end

    // Offer held steady under backpressure, released by one ready pulse.
    reset_dut();
    signal_in = 4'h4;
    wait_valid("t2_wait", 40);
    check("t2_evt", {signal_out, evt_ch, evt_level}, {4'h4, 2'd2, 1'b1});
    s0 = snap();
    nchg = 0;
    repeat (20) begin
      step(1);
      if (snap() !== s0) nchg++;
    end
    check("t2_hold_changes", nchg, 0);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t2_ack", evt_valid, 1'b0);

    // Simultaneous commits drain two cycles apart.
    reset_dut();
    evt_ready = 1'b1;
    signal_in = 4'hD;
    wait_valid("t4_wait", 40);
    check("t4_e0", {evt_ch, evt_level}, {2'd0, 1'b1});
    step(1);
    check("t4_gap0", evt_valid, 1'b0);
    step(1);
    check("t4_e1", {evt_valid, evt_ch, evt_level}, {1'b1, 2'd2, 1'b1});
    step(1);
    check("t4_gap1", evt_valid, 1'b0);
    step(1);
    check("t4_e2", {evt_valid, evt_ch, evt_level}, {1'b1, 2'd3, 1'b1});
    step(4);
    check("t4_drained", evt_valid, 1'b0);
    evt_ready = 1'b0;

    // Overflow: second commit while one is pending overwrites it.
    reset_dut();
    signal_in = 4'h2;
    wait_valid("t5_wait", 40);
    check("t5_first", {evt_ch, evt_level, overflow}, {2'd1, 1'b1, 1'b0});
    signal_in = 4'h0;
    for (int k = 0; k < 40 && signal_out[1] !== 1'b0; k++) step(1);
    check("t5_fall", {signal_out[1], overflow}, {1'b0, 1'b0});
    signal_in = 4'h2;
    for (int k = 0; k < 40 && signal_out[1] !== 1'b1; k++) step(1);
    check("t5_ovf", {signal_out[1], overflow}, {1'b1, 1'b1});
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t5_ack0", evt_valid, 1'b0);
    step(1);
    check("t5_second", {evt_valid, evt_ch, evt_level}, {1'b1, 2'd1, 1'b1});
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t5_ack1", {evt_valid, overflow}, {1'b0, 1'b1});

    // Disable mid-count discards accumulated ticks.
    rst_n = 1'b0; enable = 1'b1; signal_in = 4'h0; evt_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    signal_in = 4'h8;
    step(10);
    check("t6_pre", signal_out[3], 1'b0);
    enable = 1'b0;
    step(10);
    enable = 1'b1;
    step(11);
    check("t6_hold", signal_out[3], 1'b0);
    step(1);
    check("t6_commit", signal_out[3], 1'b1);

    // Randomized run against the model.
    rst_n = 1'b0; enable = 1'b1; signal_in = 4'h0; evt_ready = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 2) begin
        int b;
        rst_n = ($urandom_range(0, 599) != 0);
        enable = ($urandom_range(0, 39) != 0);
        if ($urandom_range(0, 11) == 0) begin
          b = $urandom_range(0, 3);
          signal_in[b] = ~signal_in[b];
        end
        evt_ready = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk);
      model_step(rst_n, enable, signal_in, evt_ready);
      #1;
      check($sformatf("rand_c%0d", c), snap(), {m_out, m_valid, m_ch, m_lvl, m_ovf});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
